usb_fs_nb_out_pe: RTL and testbench
===================================

# usb_fs_nb_out_pe

Non-buffered USB full-speed protocol engine for OUT and SETUP transactions, device side. It sits between the USB receive path (token/data decode) and the per-endpoint OUT buffers, writing payload bytes straight into the selected endpoint. The handshake (ACK/NAK/STALL) goes to the transmit path. It is the receive-direction counterpart of the IN protocol engine.

## Interface
- NumOutEps, 12: number of implemented OUT endpoints (1..16); OutEpW = $clog2(NumOutEps)
- MaxOutPktSizeByte, 32: maximum payload bytes; PktW = $clog2(MaxOutPktSizeByte)
- RxTimeoutCycles, 128: cycles allowed from end of token to start of data packet (timeout feature only)
- clk_48mhz_i  in  1  sole clock
- rst_ni  in  1  reset, asynchronous, active-low
- link_reset_i  in  1  synchronous bus reset
- dev_addr_i  in  7  device address
- out_ep_current_o  out  4  endpoint of the current transaction (0 if unimplemented)
- out_ep_newpkt_o  out  1  pulse: new OUT/SETUP transaction started
- out_ep_setup_o  out  1  current transaction is SETUP
- out_ep_put_addr_o  out  PktW  byte offset of out_ep_data_o
- out_ep_data_o  out  8  payload byte
- out_ep_data_put_o  out  1  pulse: write out_ep_data_o at out_ep_put_addr_o
- out_ep_acked_o  out  1  pulse: packet committed
- out_ep_rollback_o  out  1  pulse: discard written bytes
- out_ep_full_i  in  NumOutEps  endpoint cannot accept a packet
- out_ep_stall_i  in  NumOutEps  endpoint stalled
- out_ep_iso_i  in  NumOutEps  endpoint isochronous
- data_toggle_clear_i  in  NumOutEps  clear toggle to DATA0
- rx_pkt_start_i, rx_pkt_end_i, rx_pkt_valid_i  in  1 each  packet strobes; valid qualifies end
- rx_pid_i  in  4; rx_addr_i  in  7; rx_endp_i  in  4  fields of last packet
- rx_data_put_i  in  1; rx_data_i  in  8  payload byte strobe (CRC stripped upstream)
- tx_pkt_start_o  out  1  pulse: send handshake
- tx_pid_o  out  4  handshake PID, held until tx_pkt_end_i
- tx_pkt_end_i  in  1  handshake sent

## Operation
- States: StIdle, StRcvdToken, StRcvdData, StSendHs.
- StIdle: valid OUT/SETUP token with rx_addr_i == dev_addr_i triggers latching of endpoint, ep_impl ({1'b0,rx_endp_i} < NumOutEps) and setup flag. It also pulses newpkt and moves to StRcvdToken. A SETUP token to an implemented endpoint forces its toggle to DATA0.
- StRcvdToken: rx_pkt_start_i moves to StRcvdData and zeroes put_addr and the overflow flag. A new matching token restarts the transaction (pulse rollback).
- StRcvdData: each rx_data_put_i forwards a byte if ep_impl, the endpoint is not full, and it is either SETUP or not stalled. put_addr increments after each put. The byte after put_addr == MaxOutPktSizeByte-1 sets the overflow flag and is suppressed; put_addr does not wrap.
- On rx_pkt_end_i in StRcvdData, the first matching rule applies:
  - invalid packet or non-DATA PID: rollback, go to StIdle, no handshake
  - unimplemented endpoint, or stalled non-SETUP: STALL, rollback
  - ISO endpoint: acked if no overflow, else rollback; no handshake, toggle untouched, go to StIdle
  - full or overflow: NAK, rollback
  - SETUP with DATA1: rollback, StIdle, no handshake
  - PID toggle ≠ expected: ACK, rollback, toggle unchanged (duplicate)
  - otherwise: ACK, acked, toggle flips; out_ep_setup_o stays valid during acked
- StSendHs: wait for tx_pkt_end_i, then go to StIdle.
- Toggle update order: SETUP token force, then ACK flip, then & ~data_toggle_clear_i.
- link_reset_i: StIdle, all toggles 0, put_addr 0, no rollback pulse.

## Timing
- Reset: every output 0; state StIdle; toggles 0.
- newpkt, out_ep_current_o and out_ep_setup_o change 1 cycle after the token's rx_pkt_end_i.
- out_ep_data_put_o and out_ep_data_o are registered, 1 cycle after rx_data_put_i.
- acked, rollback and tx_pkt_start_o pulse 1 cycle after the data rx_pkt_end_i, in the same cycle as each other.
- tx_pid_o is stable from tx_pkt_start_o until tx_pkt_end_i.
- rx_pkt_end_i and rx_data_put_i in the same cycle: the byte is accepted first.

## Configuration
- USB_FS_NB_OUT_PE_TIMEOUT_EN defined: a counter runs in StRcvdToken. After RxTimeoutCycles cycles without rx_pkt_start_i, the engine pulses rollback and returns to StIdle.
- Undefined: no counter; StRcvdToken waits indefinitely. It is left only by a data start, a new token or link reset.

## Structure
- usb_consts_pkg holds the PID enum, the PID type enum and the handshake encodings.
- out_pe_state_e is local to the module.
- One sub-module: usb_fs_nb_out_toggle, the per-endpoint toggle register with force/flip/clear.

## Test plan
- OUT ep1, DATA0, 8 bytes, ep not full -> 8 puts at addresses 0..7, ACK, acked, ep1 toggle becomes 1.
- Repeat same packet with DATA0 -> ACK, rollback, no acked, toggle stays 1.
- SETUP ep0 with ep0 stalled, DATA0, 8 bytes -> setup=1, ACK, acked, toggle 1. Then OUT DATA1 with ep0 stalled -> STALL, rollback.
- OUT ep2 with out_ep_full_i[2]=1 -> no puts, NAK, rollback. OUT ep15 with NumOutEps=12 -> out_ep_current_o=0, STALL.
- 33-byte DATA0 to a non-ISO ep -> 32 puts, NAK, rollback. Same on an ISO ep -> rollback, no handshake.
- link_reset_i mid-StRcvdData -> StIdle, toggles 0, no acked/rollback. With timeout enabled, no data for 128 cycles -> rollback.

Source files
------------

// File: rtl/usb_consts_pkg.sv
// USB protocol constants shared by the full-speed protocol engines:
// PID encodings, PID type field and handshake PIDs.
package usb_consts_pkg;

  typedef enum logic [3:0] {
    UsbPidOut   = 4'b0001,
    UsbPidIn    = 4'b1001,
    UsbPidSof   = 4'b0101,
    UsbPidSetup = 4'b1101,
    UsbPidData0 = 4'b0011,
    UsbPidData1 = 4'b1011,
    UsbPidAck   = 4'b0010,
    UsbPidNak   = 4'b1010,
    UsbPidStall = 4'b1110
  } usb_pid_e;

  // PID[1:0] identifies the packet class.
  typedef enum logic [1:0] {
    UsbPidTypeSpecial   = 2'b00,
    UsbPidTypeToken     = 2'b01,
    UsbPidTypeHandshake = 2'b10,
    UsbPidTypeData      = 2'b11
  } usb_pid_type_e;

  localparam logic [3:0] HsAck   = UsbPidAck;
  localparam logic [3:0] HsNak   = UsbPidNak;
  localparam logic [3:0] HsStall = UsbPidStall;

endpackage

// File: rtl/usb_fs_nb_out_toggle.sv
// Per-endpoint OUT data toggle bits: SETUP force to DATA0, ACK flip, then
// external clear; bus reset returns every endpoint to DATA0.
module usb_fs_nb_out_toggle #(
  parameter int unsigned NumOutEps = 12,
  localparam int unsigned OutEpW   = $clog2(NumOutEps)
) (
  input  logic                 clk_48mhz_i,
  input  logic                 rst_ni,
  input  logic                 link_reset_i,
  input  logic                 force_en_i,
  input  logic [OutEpW-1:0]    force_ep_i,
  input  logic                 flip_en_i,
  input  logic [OutEpW-1:0]    flip_ep_i,
  input  logic [NumOutEps-1:0] clear_i,
  output logic [NumOutEps-1:0] toggle_o
);

  logic [NumOutEps-1:0] toggle_d, toggle_q;

  always_comb begin
    toggle_d = toggle_q;
    if (force_en_i) toggle_d[force_ep_i] = 1'b0;
    if (flip_en_i)  toggle_d[flip_ep_i]  = ~toggle_d[flip_ep_i];
    toggle_d = toggle_d & ~clear_i;
    if (link_reset_i) toggle_d = '0;
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) toggle_q <= '0;
    else         toggle_q <= toggle_d;
  end

  assign toggle_o = toggle_q;

endmodule

// File: rtl/usb_fs_nb_out_pe.sv
// Non-buffered full-speed OUT/SETUP protocol engine (device side).
// Optional token-to-data timeout: define USB_FS_NB_OUT_PE_TIMEOUT_EN.
module usb_fs_nb_out_pe
  import usb_consts_pkg::*;
#(
  parameter int unsigned NumOutEps         = 12,
  parameter int unsigned MaxOutPktSizeByte = 32,
  parameter int unsigned RxTimeoutCycles   = 128,
  localparam int unsigned OutEpW           = $clog2(NumOutEps),
  localparam int unsigned PktW             = $clog2(MaxOutPktSizeByte)
) (
  input  logic                 clk_48mhz_i,
  input  logic                 rst_ni,
  input  logic                 link_reset_i,
  input  logic [6:0]           dev_addr_i,
  output logic [3:0]           out_ep_current_o,
  output logic                 out_ep_newpkt_o,
  output logic                 out_ep_setup_o,
  output logic [PktW-1:0]      out_ep_put_addr_o,
  output logic [7:0]           out_ep_data_o,
  output logic                 out_ep_data_put_o,
  output logic                 out_ep_acked_o,
  output logic                 out_ep_rollback_o,
  input  logic [NumOutEps-1:0] out_ep_full_i,
  input  logic [NumOutEps-1:0] out_ep_stall_i,
  input  logic [NumOutEps-1:0] out_ep_iso_i,
  input  logic [NumOutEps-1:0] data_toggle_clear_i,
  input  logic                 rx_pkt_start_i,
  input  logic                 rx_pkt_end_i,
  input  logic                 rx_pkt_valid_i,
  input  logic [3:0]           rx_pid_i,
  input  logic [6:0]           rx_addr_i,
  input  logic [3:0]           rx_endp_i,
  input  logic                 rx_data_put_i,
  input  logic [7:0]           rx_data_i,
  output logic                 tx_pkt_start_o,
  output logic [3:0]           tx_pid_o,
  input  logic                 tx_pkt_end_i
);

  typedef enum logic [1:0] {StIdle, StRcvdToken, StRcvdData, StSendHs} out_pe_state_e;

  out_pe_state_e state_d, state_q;
  logic [3:0]      cur_ep_d, cur_ep_q;
  logic            ep_impl_d, ep_impl_q, setup_d, setup_q;
  logic [PktW-1:0] put_addr_d, put_addr_q, addr_out_d, addr_out_q;
  logic            last_d, last_q, overflow_d, overflow_q;
  logic [7:0]      data_d, data_q;
  logic            data_put_d, data_put_q, newpkt_d, newpkt_q;
  logic            acked_d, acked_q, rollback_d, rollback_q, tx_start_d, tx_start_q;
  logic [3:0]      tx_pid_d, tx_pid_q;
  logic            force_en, flip_en, tmo_expired;
  logic [NumOutEps-1:0] toggle;
  logic [OutEpW-1:0]    ep_idx;

  logic token_match, tok_setup, tok_impl, fwd_ok;

  assign ep_idx    = cur_ep_q[OutEpW-1:0];
  assign tok_setup = (rx_pid_i == UsbPidSetup);
  assign tok_impl  = ({1'b0, rx_endp_i} < 5'(NumOutEps));
  assign token_match = rx_pkt_end_i && rx_pkt_valid_i && (rx_addr_i == dev_addr_i) &&
                       ((rx_pid_i == UsbPidOut) || tok_setup);
  assign fwd_ok = ep_impl_q && !out_ep_full_i[ep_idx] && (setup_q || !out_ep_stall_i[ep_idx]);

`ifdef USB_FS_NB_OUT_PE_TIMEOUT_EN
  localparam int unsigned TmoW = $clog2(RxTimeoutCycles);
  logic [TmoW-1:0] tmo_q;

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tmo_q <= '0;
    end else if (state_q != StRcvdToken || token_match || link_reset_i) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_expired = (state_q == StRcvdToken) && (tmo_q == TmoW'(RxTimeoutCycles - 1));
`else
  logic unused_tmo;
  assign unused_tmo  = ^RxTimeoutCycles;
  assign tmo_expired = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    cur_ep_d   = cur_ep_q;
    ep_impl_d  = ep_impl_q;
    setup_d    = setup_q;
    put_addr_d = put_addr_q;
    addr_out_d = addr_out_q;
    last_d     = last_q;
    overflow_d = overflow_q;
    data_d     = data_q;
    tx_pid_d   = tx_pid_q;
    data_put_d = 1'b0;
    newpkt_d   = 1'b0;
    acked_d    = 1'b0;
    rollback_d = 1'b0;
    tx_start_d = 1'b0;
    force_en   = 1'b0;
    flip_en    = 1'b0;

    unique case (state_q)
      StIdle, StRcvdToken: begin
        if (token_match) begin
          cur_ep_d   = tok_impl ? rx_endp_i : 4'd0;
          ep_impl_d  = tok_impl;
          setup_d    = tok_setup;
          newpkt_d   = 1'b1;
          force_en   = tok_setup && tok_impl;
          rollback_d = (state_q == StRcvdToken);
          state_d    = StRcvdToken;
        end else if (state_q == StRcvdToken && rx_pkt_start_i) begin
          put_addr_d = '0;
          last_d     = 1'b0;
          overflow_d = 1'b0;
          state_d    = StRcvdData;
        end else if (tmo_expired) begin
          rollback_d = 1'b1;
          state_d    = StIdle;
        end
      end
      StRcvdData: begin
        // A byte arriving with the end strobe is accounted for before the verdict.
        if (rx_data_put_i) begin
          if (last_q) begin
            overflow_d = 1'b1;
          end else begin
            if (fwd_ok) begin
              data_put_d = 1'b1;
              data_d     = rx_data_i;
              addr_out_d = put_addr_q;
            end
            if (put_addr_q == PktW'(MaxOutPktSizeByte - 1)) last_d = 1'b1;
            else put_addr_d = put_addr_q + 1'b1;
          end
        end
        if (rx_pkt_end_i) begin
          state_d = StIdle;
          if (!rx_pkt_valid_i || !((rx_pid_i == UsbPidData0) || (rx_pid_i == UsbPidData1))) begin
            rollback_d = 1'b1;
          end else if (!ep_impl_q || (out_ep_stall_i[ep_idx] && !setup_q)) begin
            {tx_start_d, rollback_d, state_d, tx_pid_d} = {2'b11, StSendHs, HsStall};
          end else if (out_ep_iso_i[ep_idx]) begin
            acked_d    = !overflow_d;
            rollback_d = overflow_d;
          end else if (out_ep_full_i[ep_idx] || overflow_d) begin
            {tx_start_d, rollback_d, state_d, tx_pid_d} = {2'b11, StSendHs, HsNak};
          end else if (setup_q && rx_pid_i == UsbPidData1) begin
            rollback_d = 1'b1;
          end else begin
            {tx_start_d, state_d, tx_pid_d} = {1'b1, StSendHs, HsAck};
            if (rx_pid_i[3] != toggle[ep_idx]) begin
              rollback_d = 1'b1;
            end else begin
              acked_d = 1'b1;
              flip_en = 1'b1;
            end
          end
        end
      end
      StSendHs: if (tx_pkt_end_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    if (link_reset_i) begin
      state_d    = StIdle;
      put_addr_d = '0;
      addr_out_d = '0;
      data_put_d = 1'b0;
      newpkt_d   = 1'b0;
      acked_d    = 1'b0;
      rollback_d = 1'b0;
      tx_start_d = 1'b0;
      force_en   = 1'b0;
      flip_en    = 1'b0;
    end
  end

  always_ff @(posedge clk_48mhz_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= StIdle;
      cur_ep_q   <= '0;
      ep_impl_q  <= 1'b0;
      setup_q    <= 1'b0;
      put_addr_q <= '0;
      addr_out_q <= '0;
      last_q     <= 1'b0;
      overflow_q <= 1'b0;
      data_q     <= '0;
      data_put_q <= 1'b0;
      newpkt_q   <= 1'b0;
      acked_q    <= 1'b0;
      rollback_q <= 1'b0;
      tx_start_q <= 1'b0;
      tx_pid_q   <= '0;
    end else begin
      state_q    <= state_d;
      cur_ep_q   <= cur_ep_d;
      ep_impl_q  <= ep_impl_d;
      setup_q    <= setup_d;
      put_addr_q <= put_addr_d;
      addr_out_q <= addr_out_d;
      last_q     <= last_d;
      overflow_q <= overflow_d;
      data_q     <= data_d;
      data_put_q <= data_put_d;
      newpkt_q   <= newpkt_d;
      acked_q    <= acked_d;
      rollback_q <= rollback_d;
      tx_start_q <= tx_start_d;
      tx_pid_q   <= tx_pid_d;
    end
  end

  usb_fs_nb_out_toggle #(
    .NumOutEps (NumOutEps)
  ) u_toggle (
    .clk_48mhz_i  (clk_48mhz_i),
    .rst_ni       (rst_ni),
    .link_reset_i (link_reset_i),
    .force_en_i   (force_en),
    .force_ep_i   (rx_endp_i[OutEpW-1:0]),
    .flip_en_i    (flip_en),
    .flip_ep_i    (ep_idx),
    .clear_i      (data_toggle_clear_i),
    .toggle_o     (toggle)
  );

  assign out_ep_current_o  = cur_ep_q;
  assign out_ep_newpkt_o   = newpkt_q;
  assign out_ep_setup_o    = setup_q;
  assign out_ep_put_addr_o = addr_out_q;
  assign out_ep_data_o     = data_q;
  assign out_ep_data_put_o = data_put_q;
  assign out_ep_acked_o    = acked_q;
  assign out_ep_rollback_o = rollback_q;
  assign tx_pkt_start_o    = tx_start_q;
  assign tx_pid_o          = tx_pid_q;

endmodule

// File: tb/tb_usb_fs_nb_out_pe.sv
// Directed self-checking bench for usb_fs_nb_out_pe: transactions are driven
// on the falling edge and pulse outputs are logged on the falling edge.
module tb_usb_fs_nb_out_pe;

  localparam logic [3:0] PidOut = 4'b0001, PidSetup = 4'b1101;
  localparam logic [3:0] PidD0 = 4'b0011, PidD1 = 4'b1011;
  localparam logic [3:0] PidAck = 4'b0010, PidNak = 4'b1010, PidStall = 4'b1110;
  localparam logic [6:0] DevAddr = 7'h05;

  logic clk = 1'b0, rst_n = 1'b0, link_reset = 1'b0;
  logic [3:0] cur;
  logic newpkt, setup, data_put, acked, rollback, tx_start, tx_end = 1'b0;
  logic [4:0] put_addr;
  logic [7:0] data, rx_data = '0;
  logic [3:0] tx_pid, rx_pid = '0, rx_endp = '0;
  logic [11:0] full = '0, stall = '0, iso = '0, tog_clr = '0;
  logic rx_start = 1'b0, rx_end = 1'b0, rx_valid = 1'b0, rx_put = 1'b0;
  logic [6:0] rx_addr = '0;

  int n_checks = 0, n_fail = 0;
  int cyc = 0, end_cyc = 0;
  int n_put, n_acked, n_rb, n_tx, n_new, acked_cyc, rb_cyc, tx_cyc, new_cyc;
  logic [3:0] last_pid;
  logic setup_at_ack;
  logic [4:0] addr_log [64];
  logic [7:0] data_log [64];

  always #10 clk = ~clk;

  usb_fs_nb_out_pe dut (
    .clk_48mhz_i         (clk),
    .rst_ni              (rst_n),
    .link_reset_i        (link_reset),
    .dev_addr_i          (DevAddr),
    .out_ep_current_o    (cur),
    .out_ep_newpkt_o     (newpkt),
    .out_ep_setup_o      (setup),
    .out_ep_put_addr_o   (put_addr),
    .out_ep_data_o       (data),
    .out_ep_data_put_o   (data_put),
    .out_ep_acked_o      (acked),
    .out_ep_rollback_o   (rollback),
    .out_ep_full_i       (full),
    .out_ep_stall_i      (stall),
    .out_ep_iso_i        (iso),
    .data_toggle_clear_i (tog_clr),
    .rx_pkt_start_i      (rx_start),
    .rx_pkt_end_i        (rx_end),
    .rx_pkt_valid_i      (rx_valid),
    .rx_pid_i            (rx_pid),
    .rx_addr_i           (rx_addr),
    .rx_endp_i           (rx_endp),
    .rx_data_put_i       (rx_put),
    .rx_data_i           (rx_data),
    .tx_pkt_start_o      (tx_start),
    .tx_pid_o            (tx_pid),
    .tx_pkt_end_i        (tx_end)
  );

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rst_n) begin
      if (data_put) begin
        if (n_put < 64) begin
          addr_log[n_put] = put_addr;
          data_log[n_put] = data;
        end
        n_put++;
      end
      if (acked)    begin n_acked++; acked_cyc = cyc; setup_at_ack = setup; end
      if (rollback) begin n_rb++; rb_cyc = cyc; end
      if (tx_start) begin n_tx++; tx_cyc = cyc; last_pid = tx_pid; end
      if (newpkt)   begin n_new++; new_cyc = cyc; end
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_counts();
    n_put = 0; n_acked = 0; n_rb = 0; n_tx = 0; n_new = 0;
    acked_cyc = -1; rb_cyc = -2; tx_cyc = -3; new_cyc = -4;
    last_pid = '0; setup_at_ack = 1'b0;
  endtask

  task automatic send_token(input logic [3:0] pid, input logic [6:0] addr, input logic [3:0] ep);
    @(negedge clk);
    rx_end = 1'b1; rx_valid = 1'b1; rx_pid = pid; rx_addr = addr; rx_endp = ep;
    end_cyc = cyc;
    @(negedge clk);
    rx_end = 1'b0; rx_valid = 1'b0;
  endtask

  // merge_last: the final byte shares its cycle with the end strobe.
  task automatic send_data(input logic [3:0] pid, input int n, input bit merge_last);
    @(negedge clk);
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    for (int i = 0; i < n - (merge_last ? 1 : 0); i++) begin
      rx_put = 1'b1; rx_data = 8'(8'hA0 + i);
      @(negedge clk);
    end
    rx_put = merge_last; rx_data = 8'(8'hA0 + n - 1);
    rx_end = 1'b1; rx_valid = 1'b1; rx_pid = pid;
    end_cyc = cyc;
    @(negedge clk);
    rx_end = 1'b0; rx_valid = 1'b0; rx_put = 1'b0;
  endtask

  task automatic finish_hs();
    repeat (3) @(negedge clk);
    tx_end = 1'b1;
    @(negedge clk);
    tx_end = 1'b0;
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic txn(input logic [3:0] tpid, input logic [3:0] ep, input logic [3:0] dpid,
                     input int n, input bit merge_last);
    clear_counts();
    send_token(tpid, DevAddr, ep);
    send_data(dpid, n, merge_last);
    finish_hs();
  endtask

  initial begin
    clear_counts();
    repeat (3) @(negedge clk);
    check_eq("rst_current", {28'd0, cur}, 32'd0);
    check_eq("rst_pulses", {26'd0, newpkt, data_put, acked, rollback, tx_start, setup}, 32'd0);
    check_eq("rst_tx_pid", {28'd0, tx_pid}, 32'd0);
    check_eq("rst_put_addr", {27'd0, put_addr}, 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // OUT ep1 DATA0, 8 bytes
    clear_counts();
    send_token(PidOut, DevAddr, 4'd1);
    #1;
    check_eq("tok_newpkt", n_new, 1);
    check_eq("tok_newpkt_lat", new_cyc, end_cyc + 1);
    check_eq("tok_current", {28'd0, cur}, 32'd1);
    check_eq("tok_setup", {31'd0, setup}, 32'd0);
    send_data(PidD0, 8, 1'b0);
    finish_hs();
    check_eq("d0_puts", n_put, 8);
    for (int i = 0; i < 8; i++) begin
      check_eq($sformatf("d0_addr%0d", i), {27'd0, addr_log[i]}, i);
      check_eq($sformatf("d0_data%0d", i), {24'd0, data_log[i]}, 32'hA0 + i);
    end
    check_eq("d0_acked", n_acked, 1);
    check_eq("d0_rb", n_rb, 0);
    check_eq("d0_tx", n_tx, 1);
    check_eq("d0_pid", {28'd0, last_pid}, {28'd0, PidAck});
    check_eq("d0_ack_lat", acked_cyc, end_cyc + 1);
    check_eq("d0_ack_tx_same", acked_cyc, tx_cyc);

    // Duplicate DATA0 on ep1
    txn(PidOut, 4'd1, PidD0, 8, 1'b0);
    check_eq("dup_pid", {28'd0, last_pid}, {28'd0, PidAck});
    check_eq("dup_acked", n_acked, 0);
    check_eq("dup_rb", n_rb, 1);
    check_eq("dup_rb_tx_same", rb_cyc, tx_cyc);

    // ep1 now expects DATA1
    txn(PidOut, 4'd1, PidD1, 3, 1'b0);
    check_eq("d1_acked", n_acked, 1);

    // SETUP ep0 while stalled
    stall[0] = 1'b1;
    txn(PidSetup, 4'd0, PidD0, 8, 1'b0);
    check_eq("setup_puts", n_put, 8);
    check_eq("setup_flag_at_ack", {31'd0, setup_at_ack}, 32'd1);
    check_eq("setup_pid", {28'd0, last_pid}, {28'd0, PidAck});
    check_eq("setup_acked", n_acked, 1);
    txn(PidOut, 4'd0, PidD1, 4, 1'b0);
    check_eq("stall_pid", {28'd0, last_pid}, {28'd0, PidStall});
    check_eq("stall_rb", n_rb, 1);
    check_eq("stall_puts", n_put, 0);
    stall[0] = 1'b0;

    // Full endpoint
    full[2] = 1'b1;
    txn(PidOut, 4'd2, PidD0, 4, 1'b0);
    check_eq("full_puts", n_put, 0);
    check_eq("full_pid", {28'd0, last_pid}, {28'd0, PidNak});
    check_eq("full_rb", n_rb, 1);
    full[2] = 1'b0;

    // Unimplemented endpoint
    txn(PidOut, 4'd15, PidD0, 4, 1'b0);
    check_eq("unimpl_current", {28'd0, cur}, 32'd0);
    check_eq("unimpl_newpkt", n_new, 1);
    check_eq("unimpl_pid", {28'd0, last_pid}, {28'd0, PidStall});
    check_eq("unimpl_rb", n_rb, 1);

    // Overflow on non-ISO ep3, last byte merged with end
    txn(PidOut, 4'd3, PidD0, 33, 1'b1);
    check_eq("ovf_puts", n_put, 32);
    check_eq("ovf_last_addr", {27'd0, addr_log[31]}, 32'd31);
    check_eq("ovf_pid", {28'd0, last_pid}, {28'd0, PidNak});
    check_eq("ovf_rb", n_rb, 1);
    check_eq("ovf_acked", n_acked, 0);
    // Exactly max size, toggle still DATA0
    txn(PidOut, 4'd3, PidD0, 32, 1'b1);
    check_eq("max_puts", n_put, 32);
    check_eq("max_acked", n_acked, 1);
    check_eq("max_pid", {28'd0, last_pid}, {28'd0, PidAck});

    // ISO endpoint
    iso[4] = 1'b1;
    txn(PidOut, 4'd4, PidD0, 33, 1'b0);
    check_eq("iso_ovf_rb", n_rb, 1);
    check_eq("iso_ovf_tx", n_tx, 0);
    check_eq("iso_ovf_acked", n_acked, 0);
    txn(PidOut, 4'd4, PidD0, 4, 1'b0);
    check_eq("iso_acked", n_acked, 1);
    check_eq("iso_tx", n_tx, 0);
    iso[4] = 1'b0;

    // Token for another device is ignored
    clear_counts();
    send_token(PidOut, 7'h06, 4'd1);
    repeat (2) @(negedge clk);
    #1;
    check_eq("wrong_addr_newpkt", n_new, 0);

    // Link reset mid-data after ep5 has toggled to 1
    txn(PidOut, 4'd5, PidD0, 2, 1'b0);
    check_eq("ep5_acked", n_acked, 1);
    clear_counts();
    send_token(PidOut, DevAddr, 4'd5);
    @(negedge clk);
    rx_start = 1'b1;
    @(negedge clk);
    rx_start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rx_put = 1'b1; rx_data = 8'(i);
      @(negedge clk);
    end
    rx_put = 1'b0; link_reset = 1'b1;
    @(negedge clk);
    link_reset = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("lr_puts", n_put, 3);
    check_eq("lr_acked", n_acked, 0);
    check_eq("lr_rb", n_rb, 0);
    check_eq("lr_put_addr", {27'd0, put_addr}, 32'd0);
    txn(PidOut, 4'd5, PidD0, 2, 1'b0);
    check_eq("lr_toggle0_acked", n_acked, 1);

    // Toggle clear: ep1 to 1, clear, DATA0 accepted again
    txn(PidOut, 4'd1, PidD0, 2, 1'b0);
    check_eq("clr_pre_acked", n_acked, 1);
    @(negedge clk);
    tog_clr[1] = 1'b1;
    @(negedge clk);
    tog_clr[1] = 1'b0;
    txn(PidOut, 4'd1, PidD0, 2, 1'b0);
    check_eq("clr_post_acked", n_acked, 1);
    check_eq("clr_post_rb", n_rb, 0);

    // Long wait between token and data
    clear_counts();
    send_token(PidOut, DevAddr, 4'd6);
    repeat (200) @(negedge clk);
    #1;
`ifdef USB_FS_NB_OUT_PE_TIMEOUT_EN
    check_eq("tmo_rb", n_rb, 1);
`else
    check_eq("tmo_rb", n_rb, 0);
    send_data(PidD0, 2, 1'b0);
    finish_hs();
    check_eq("tmo_late_acked", n_acked, 1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
